// File: rtl/trigger_stream_word_aligner.sv
// trigger_stream_word_aligner: finds the bit offset of the 8-word trigger frame, checks each word and tracks lock.
// Optional error_count port enabled by defining TRIGGER_RX_ERROR_COUNTER_EN.
module trigger_stream_word_aligner #(
    parameter int LOCK_FRAMES = 2,
    parameter int LOSS_FRAMES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  word_in,
`ifdef TRIGGER_RX_ERROR_COUNTER_EN
    output logic [15:0] error_count,
`endif
    output logic [7:0]  aligned_word,
    output logic        word_valid,
    output logic        frame_start,
    output logic        frame_good,
    output logic        frame_bad,
    output logic        locked,
    output logic [2:0]  bit_offset,
    output logic [2:0]  word_index
);
    localparam logic [63:0] FRAME  = 64'hFFFF_F399_8001_CCAA;
    localparam logic [4:0]  LOCK_N = 5'(LOCK_FRAMES);
    localparam logic [4:0]  LOSS_N = 5'(LOSS_FRAMES);

    typedef enum logic {SEARCH, CHECK} state_t;

    state_t      state_q;
    logic [23:0] sr_q;
    logic [2:0]  idx_q, off_q, widx_q;
    logic [7:0]  aligned_q;
    logic        valid_q, start_q, good_q, bad_q, locked_q;
    logic [3:0]  good_cnt_q, bad_cnt_q;
    logic        hit, good_d, bad_d;
    logic [2:0]  hit_k;
    logic [7:0]  cur, exp_w;

    // Descending scan so the smallest matching offset is the one kept
    always_comb begin
        hit = 1'b0;
        hit_k = 3'd0;
        for (int k = 7; k >= 0; k--)
            if (sr_q[15-k -: 8] == 8'hFF && sr_q[23-k -: 8] == 8'h00) begin
                hit = 1'b1;
                hit_k = 3'(k);
            end
    end

    assign cur    = sr_q[15-off_q -: 8];
    assign exp_w  = FRAME[63-8*idx_q -: 8];
    assign good_d = state_q == CHECK && cur == exp_w && idx_q == 3'd7;
    assign bad_d  = state_q == CHECK ? cur != exp_w : hit && locked_q && hit_k != off_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= SEARCH;
            sr_q       <= '0;
            idx_q      <= '0;
            off_q      <= '0;
            widx_q     <= '0;
            aligned_q  <= '0;
            valid_q    <= 1'b0;
            start_q    <= 1'b0;
            good_q     <= 1'b0;
            bad_q      <= 1'b0;
            locked_q   <= 1'b0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
        end else begin
            sr_q    <= {sr_q[15:0], word_in};
            valid_q <= 1'b0;
            start_q <= 1'b0;
            good_q  <= good_d;
            bad_q   <= bad_d;
            if (state_q == SEARCH) begin
                if (hit) begin
                    aligned_q <= 8'hFF;
                    widx_q    <= 3'd0;
                    valid_q   <= 1'b1;
                    start_q   <= 1'b1;
                    off_q     <= hit_k;
                    idx_q     <= 3'd1;
                    state_q   <= CHECK;
                end
            end else begin
                aligned_q <= cur;
                valid_q   <= 1'b1;
                widx_q    <= idx_q;
                if (cur != exp_w || idx_q == 3'd7)
                    state_q <= SEARCH;
                else
                    idx_q <= idx_q + 3'd1;
            end
            if (good_d) begin
                bad_cnt_q  <= '0;
                good_cnt_q <= good_cnt_q == 4'hF ? 4'hF : good_cnt_q + 4'd1;
                if ({1'b0, good_cnt_q} + 5'd1 >= LOCK_N)
                    locked_q <= 1'b1;
            end
            if (bad_d) begin
                good_cnt_q <= '0;
                bad_cnt_q  <= bad_cnt_q == 4'hF ? 4'hF : bad_cnt_q + 4'd1;
                if ({1'b0, bad_cnt_q} + 5'd1 >= LOSS_N)
                    locked_q <= 1'b0;
            end
        end
    end

`ifdef TRIGGER_RX_ERROR_COUNTER_EN
    logic [15:0] err_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            err_q <= '0;
        else if (bad_d && err_q != 16'hFFFF)
            err_q <= err_q + 16'd1;
    end

    assign error_count = err_q;
`endif

    assign aligned_word = aligned_q;
    assign word_valid   = valid_q;
    assign frame_start  = start_q;
    assign frame_good   = good_q;
    assign frame_bad    = bad_q;
    assign locked       = locked_q;
    assign bit_offset   = off_q;
    assign word_index   = widx_q;
endmodule

// File: tb/tb_trigger_stream_word_aligner.sv
// tb_trigger_stream_word_aligner: scoreboard bench; stimulus pushes expected output words, a monitor pops and compares.
module tb_trigger_stream_word_aligner;
    localparam logic [63:0] FRAME = 64'hFFFF_F399_8001_CCAA;
    localparam int LOCK = 2;
    localparam int LOSS = 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  word_in = 8'h00;
    logic [7:0]  aligned_word;
    logic        word_valid, frame_start, frame_good, frame_bad, locked;
    logic [2:0]  bit_offset, word_index;
`ifdef TRIGGER_RX_ERROR_COUNTER_EN
    logic [15:0] error_count;
`endif

    trigger_stream_word_aligner #(.LOCK_FRAMES(LOCK), .LOSS_FRAMES(LOSS)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .word_in(word_in),
`ifdef TRIGGER_RX_ERROR_COUNTER_EN
        .error_count(error_count),
`endif
        .aligned_word(aligned_word),
        .word_valid(word_valid),
        .frame_start(frame_start),
        .frame_good(frame_good),
        .frame_bad(frame_bad),
        .locked(locked),
        .bit_offset(bit_offset),
        .word_index(word_index)
    );

    always #4 clock = ~clock;

    // {word, index, start, good, bad, offset, locked}
    typedef logic [17:0] rec_t;

    rec_t       exp_q[$];
    int         checks = 0;
    int         passed = 0;
    logic       m_locked = 1'b0;
    int         m_good = 0;
    int         m_bad = 0;
    int         m_errs = 0;
    logic [2:0] m_off = 3'd0;

    always @(negedge clock) begin
        if (reset_n) begin
            if (word_valid) begin
                rec_t got, e;
                got = {aligned_word, word_index, frame_start, frame_good, frame_bad, bit_offset, locked};
                checks++;
                if (exp_q.size() == 0)
                    $display("FAIL unexpected_word got %h expected none", got);
                else begin
                    e = exp_q.pop_front();
                    if (got === e) passed++;
                    else $display("FAIL out_word got %h expected %h", got, e);
                end
            end else if (frame_start || frame_good || frame_bad) begin
                checks++;
                $display("FAIL stray_pulse got %b%b%b expected 000", frame_start, frame_good, frame_bad);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s got %h expected %h", name, got, exp);
    endtask

    task automatic drive(input logic [7:0] w);
        @(negedge clock);
        word_in = w;
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_good = 0;
        m_bad = 0;
        m_errs = 0;
        m_off = 3'd0;
    endtask

    task automatic count_good();
        m_bad = 0;
        if (m_good + 1 >= LOCK) m_locked = 1'b1;
        m_good = m_good < 15 ? m_good + 1 : 15;
    endtask

    task automatic count_bad();
        m_errs++;
        m_good = 0;
        if (m_bad + 1 >= LOSS) m_locked = 1'b0;
        m_bad = m_bad < 15 ? m_bad + 1 : 15;
    endtask

    // n frames at bit offset k; bad_i >= 0 flips the LSB of that frame word
    task automatic add_frames(input int k, input int n, input int bad_i);
        logic       bits[$];
        logic [63:0] fr;
        logic [7:0] b, w;
        logic       sb, alive;
        fr = FRAME;
        repeat (k) bits.push_back(1'b0);
        for (int f = 0; f < n; f++) begin
            repeat (8) bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) begin
                b = fr[63-8*i -: 8];
                if (i == bad_i) b = b ^ 8'h01;
                for (int j = 7; j >= 0; j--) bits.push_back(b[j]);
            end
            sb = m_locked && (3'(k) != m_off);
            m_off = 3'(k);
            if (sb) count_bad();
            exp_q.push_back({8'hFF, 3'd0, 1'b1, 1'b0, sb, m_off, m_locked});
            alive = 1'b1;
            for (int i = 1; i < 8; i++) begin
                if (alive) begin
                    b = fr[63-8*i -: 8];
                    if (i == bad_i) begin
                        count_bad();
                        exp_q.push_back({b ^ 8'h01, 3'(i), 1'b0, 1'b0, 1'b1, m_off, m_locked});
                        alive = 1'b0;
                    end else if (i == 7) begin
                        count_good();
                        exp_q.push_back({b, 3'(i), 1'b0, 1'b1, 1'b0, m_off, m_locked});
                    end else
                        exp_q.push_back({b, 3'(i), 1'b0, 1'b0, 1'b0, m_off, m_locked});
                end
            end
        end
        while (bits.size() % 8 != 0) bits.push_back(1'b0);
        repeat (16) bits.push_back(1'b0);
        for (int p = 0; p < bits.size(); p += 8) begin
            for (int j = 0; j < 8; j++) w[7-j] = bits[p+j];
            drive(w);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        #1 reset_n = 1'b0;
        word_in = 8'h00;
        #1 chk("reset_outputs", {13'd0, aligned_word, word_valid, frame_start, frame_good, frame_bad, locked, bit_offset, word_index}, 32'd0);
        model_reset();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [63:0] fr;
        fr = FRAME;
        // reset, then idle stream only
        repeat (3) @(negedge clock);
        chk("reset_initial", {13'd0, aligned_word, word_valid, frame_start, frame_good, frame_bad, locked, bit_offset, word_index}, 32'd0);
        reset_n = 1'b1;
        repeat (20) drive(8'h00);
        chk("idle_locked", 32'(locked), 32'd0);
        // one frame at offset 0
        add_frames(0, 1, -1);
        // reset while the frame is at word index 4: only indexes 0..2 reach the output
        for (int i = 0; i < 3; i++)
            exp_q.push_back({fr[63-8*i -: 8], 3'(i), i == 0, 1'b0, 1'b0, 3'd0, m_locked});
        drive(8'h00);
        for (int i = 0; i < 5; i++) drive(fr[63-8*i -: 8]);
        do_reset();
        chk("reset_mid_frame_drained", 32'(exp_q.size()), 32'd0);
        repeat (4) drive(8'h00);
        add_frames(0, 1, -1);
        // fresh link: three frames at offset 5, lock on the second
        do_reset();
        repeat (4) drive(8'h00);
        add_frames(5, 3, -1);
        chk("locked_after_three", 32'(locked), 32'd1);
        // two corrupted frames drop lock
        add_frames(5, 2, 4);
        chk("unlocked_after_bad", 32'(locked), 32'd0);
`ifdef TRIGGER_RX_ERROR_COUNTER_EN
        chk("error_count_two", 32'(error_count), 32'd2);
`endif
        // relock at 5, then an offset change to 2
        add_frames(5, 2, -1);
        add_frames(2, 1, -1);
        chk("locked_after_offset_change", 32'(locked), 32'd1);
        chk("offset_after_change", 32'(bit_offset), 32'd2);
        begin
            int budget;
            budget = 0;
            while (exp_q.size() != 0 && budget < 50) begin
                drive(8'h00);
                budget++;
            end
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("final_locked", 32'(locked), 32'(m_locked));
`ifdef TRIGGER_RX_ERROR_COUNTER_EN
        chk("error_count_final", 32'(error_count), 32'(m_errs));
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
